// File: rtl/fwd_prop_seq.sv
// Forward-propagation phase sequencer: steps the datapath through load/accumulate/activate/update phases.
// Optional update-handshake timeout with sticky err flag is enabled by defining FWD_SEQ_TIMEOUT_EN.
module fwd_prop_seq #(
    parameter int HACC_CYC = 1,
    parameter int ACT_CYC  = 2,
    parameter int MAX_STEP = 15,
    parameter int TO_CYC   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] st_in,
    input  logic       abort,
    input  logic       upd_ack,
    output logic [3:0] ctrl,
    output logic [3:0] step,
    output logic [3:0] st,
    output logic       busy,
    output logic       upd_req,
    output logic       done,
    output logic       ep_done
`ifdef FWD_SEQ_TIMEOUT_EN
    ,
    output logic       err
`endif
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0000,
        LOAD  = 4'b0001,
        HACC  = 4'b0010,
        HACT  = 4'b0011,
        OACC  = 4'b0100,
        OACT  = 4'b0101,
        LATCH = 4'b0110,
        DONE  = 4'b0111,
        UPD   = 4'b1000
    } state_t;

    localparam logic [3:0] HACC_LEN = 4'(HACC_CYC);
    localparam logic [3:0] ACT_LEN  = 4'(ACT_CYC);
    localparam logic [3:0] MAX_LEN  = 4'(MAX_STEP);

    if (HACC_CYC < 1 || HACC_CYC > 15 || ACT_CYC < 1 || ACT_CYC > 15 ||
        MAX_STEP < 1 || MAX_STEP > 15 || TO_CYC < 1 || TO_CYC > 255) begin : g_param_check
        $error("fwd_prop_seq: parameter out of range");
    end

    state_t     state, next_state;
    logic [3:0] cnt, next_cnt;

`ifdef FWD_SEQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);
    logic [7:0] to_cnt;
    logic       to_hit;
`endif

    // Reload value for the phase counter on entry to each timed state.
    function automatic logic [3:0] dur(input state_t s);
        case (s)
            LOAD, OACC, LATCH: dur = 4'd1;
            HACC:              dur = HACC_LEN;
            HACT, OACT:        dur = ACT_LEN;
            default:           dur = 4'd0;
        endcase
    endfunction

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
`ifdef FWD_SEQ_TIMEOUT_EN
        to_hit     = 1'b0;
`endif
        case (state)
            IDLE:  if (start) next_state = LOAD;
            LOAD:  if (cnt <= 4'd1) next_state = HACC;
            HACC:  if (cnt <= 4'd1) next_state = HACT;
            HACT:  if (cnt <= 4'd1) next_state = OACC;
            OACC:  if (cnt <= 4'd1) next_state = OACT;
            OACT:  if (cnt <= 4'd1) next_state = LATCH;
            LATCH: if (cnt <= 4'd1) next_state = UPD;
            UPD: begin
                if (upd_ack) begin
                    next_state = DONE;
                end
`ifdef FWD_SEQ_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    next_state = DONE;
                    to_hit     = 1'b1;
                end
`endif
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase

        // Abort wins over everything, including a start in the same IDLE cycle.
        if (abort) begin
            next_state = IDLE;
`ifdef FWD_SEQ_TIMEOUT_EN
            to_hit     = 1'b0;
`endif
        end

        if (next_state != state) begin
            next_cnt = dur(next_state);
        end else if (cnt > 4'd1) begin
            next_cnt = cnt - 4'd1;
        end
    end

    // Status outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            step    <= 4'd0;
            st      <= 4'd0;
            busy    <= 1'b0;
            upd_req <= 1'b0;
            done    <= 1'b0;
            ep_done <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= next_cnt;
            busy    <= (next_state != IDLE);
            upd_req <= (next_state == UPD);
            done    <= (next_state == DONE);
            ep_done <= (next_state == DONE) && (step == MAX_LEN);
            if (abort) begin
                step <= 4'd0;
            end else if (state == IDLE && start) begin
                step <= (step == 4'd0 || step == MAX_LEN) ? 4'd1 : step + 4'd1;
                st   <= st_in;
            end
        end
    end

`ifdef FWD_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= 8'd0;
            err    <= 1'b0;
        end else begin
            to_cnt <= (state == UPD && next_state == UPD) ? to_cnt + 8'd1 : 8'd0;
            if (to_hit) begin
                err <= 1'b1;
            end
        end
    end
`endif

    assign ctrl = state;

endmodule

// File: tb/tb_fwd_prop_seq.sv
// Scoreboard bench for fwd_prop_seq: directed passes push expected done records, a monitor pops on done.
module tb_fwd_prop_seq;

    localparam int HACC_CYC = 1;
    localparam int ACT_CYC  = 2;
    localparam int MAX_STEP = 15;
    localparam int PASS_LEN = 5 + HACC_CYC + 2 * ACT_CYC;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] st_in;
    logic       abort;
    logic       upd_ack;
    logic [3:0] ctrl;
    logic [3:0] step;
    logic [3:0] st;
    logic       busy;
    logic       upd_req;
    logic       done;
    logic       ep_done;
`ifdef FWD_SEQ_TIMEOUT_EN
    logic       err;
`endif

    typedef struct packed {
        logic [3:0] step;
        logic [3:0] st;
        logic       ep;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [3:0] exp_seq [11];
    int         checks = 0;
    int         errors = 0;
    int         cyc;

    fwd_prop_seq #(
        .HACC_CYC(HACC_CYC),
        .ACT_CYC (ACT_CYC),
        .MAX_STEP(MAX_STEP),
        .TO_CYC  (255)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .st_in  (st_in),
        .abort  (abort),
        .upd_ack(upd_ack),
        .ctrl   (ctrl),
        .step   (step),
        .st     (st),
        .busy   (busy),
        .upd_req(upd_req),
        .done   (done),
        .ep_done(ep_done)
`ifdef FWD_SEQ_TIMEOUT_EN
        ,
        .err    (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expected pass.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done with step %0h, expected no done", step);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("done_step", step, mon_e.step);
                checkOutput("done_st", st, mon_e.st);
                checkOutput("done_ep", ep_done, mon_e.ep);
            end
        end
        if (rst === 1'b1 && ep_done === 1'b1) begin
            checkOutput("ep_with_done", done, 1'b1);
        end
    end

    task automatic startPass(input logic [3:0] s, input logic [3:0] exp_step, input logic exp_ep, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        st_in = s;
        if (push) begin
            e.step = exp_step;
            e.st   = s;
            e.ep   = exp_ep;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        st_in = ~s;
        checkOutput("busy_in_load", busy, 1'b1);
    endtask

    task automatic finishPass(output int cycles);
        cycles = 0;
        while (ctrl !== 4'h0 && cycles < 64) begin
            upd_ack = upd_req;
            @(negedge clk);
            cycles++;
        end
        upd_ack = 1'b0;
        checkOutput("pass_end_idle", ctrl, 4'h0);
    endtask

    task automatic waitCtrl(input logic [3:0] code);
        int n;
        n = 0;
        while (ctrl !== code && n < 64) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_ctrl", ctrl, code);
    endtask

    task automatic applyStimulus(input logic [3:0] s, input logic [3:0] exp_step, input logic exp_ep);
        int c;
        startPass(s, exp_step, exp_ep, 1'b1);
        finishPass(c);
        checkOutput("pass_len", c, PASS_LEN);
        checkOutput("st_after", st, s);
        checkOutput("step_after", step, exp_step);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        upd_ack = 1'b0;
        st_in   = 4'h0;
        exp_seq = '{4'h1, 4'h2, 4'h3, 4'h3, 4'h4, 4'h5, 4'h5, 4'h6, 4'h8, 4'h7, 4'h0};

        #3 rst = 1'b0;
        #1;
        checkOutput("rst_ctrl", ctrl, 4'h0);
        checkOutput("rst_step", step, 4'h0);
        checkOutput("rst_st", st, 4'h0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_upd_req", upd_req, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_ep_done", ep_done, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // First pass: full phase sequence with a one-cycle update handshake.
        startPass(4'h3, 4'h1, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) begin
            checkOutput($sformatf("ctrl_seq_%0d", i), ctrl, exp_seq[i]);
            upd_ack = upd_req;
            @(negedge clk);
        end
        upd_ack = 1'b0;
        checkOutput("first_st", st, 4'h3);
        checkOutput("first_step", step, 4'h1);

        // Back-to-back passes up to MAX_STEP, then wrap to 1.
        for (int p = 2; p <= MAX_STEP; p++) begin
            applyStimulus(4'(p), 4'(p), (p == MAX_STEP));
        end
        applyStimulus(4'hA, 4'h1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("st_hold", st, 4'hA);

        // Abort during HACT.
        startPass(4'h5, 4'h2, 1'b0, 1'b0);
        waitCtrl(4'h3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_ctrl", ctrl, 4'h0);
        checkOutput("abort_step", step, 4'h0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_upd_req", upd_req, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("abort_stays_idle", ctrl, 4'h0);
        applyStimulus(4'h6, 4'h1, 1'b0);

        // Start pulsed during OACC is ignored and not queued.
        startPass(4'h7, 4'h2, 1'b0, 1'b1);
        waitCtrl(4'h4);
        start = 1'b1;
        st_in = 4'hC;
        @(negedge clk);
        start = 1'b0;
        checkOutput("oacc_start_ctrl", ctrl, 4'h5);
        finishPass(cyc);
        repeat (2) @(negedge clk);
        checkOutput("no_queued_ctrl", ctrl, 4'h0);
        checkOutput("no_queued_busy", busy, 1'b0);
        checkOutput("no_queued_st", st, 4'h7);
        checkOutput("no_queued_step", step, 4'h2);

        // Start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        st_in = 4'h9;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("sa_ctrl", ctrl, 4'h0);
        checkOutput("sa_busy", busy, 1'b0);
        checkOutput("sa_step", step, 4'h0);
        checkOutput("sa_st", st, 4'h7);

        // Asynchronous reset while waiting in UPD.
        startPass(4'h4, 4'h1, 1'b0, 1'b0);
        waitCtrl(4'h8);
        #2 rst = 1'b0;
        #1;
        checkOutput("arst_ctrl", ctrl, 4'h0);
        checkOutput("arst_step", step, 4'h0);
        checkOutput("arst_st", st, 4'h0);
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_upd_req", upd_req, 1'b0);
        checkOutput("arst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_ctrl", ctrl, 4'h0);
        checkOutput("post_rst_busy", busy, 1'b0);
        applyStimulus(4'hE, 4'h1, 1'b0);

        repeat (2) @(negedge clk);
        checkOutput("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_prop_seq.md
FWD_PROP_SEQ -- requirements
Module: fwd_prop_seq

Interface
Parameters (name, default, meaning)
REQ-001 The block SHALL provide parameter HACC_CYC, default 1: cycles spent in hidden-layer accumulate (1..15).
REQ-002 The block SHALL provide parameter ACT_CYC, default 2: cycles allowed for each activation stage to settle (1..15).
REQ-003 The block SHALL provide parameter MAX_STEP, default 15: last step index of an episode (1..15).
REQ-004 The block SHALL provide parameter TO_CYC, default 255: update-handshake timeout, used only when FWD_SEQ_TIMEOUT_EN is defined.

Ports (name, direction, width, meaning)
REQ-005 The block SHALL provide port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 The block SHALL provide port rst, input, 1: asynchronous, active-low reset.
REQ-007 The block SHALL provide port start, input, 1: request one forward pass; sampled only in IDLE.
REQ-008 The block SHALL provide port st_in, input, 4: state index, captured when start is accepted.
REQ-009 The block SHALL provide port abort, input, 1: synchronous return to IDLE and end of episode.
REQ-010 The block SHALL provide port upd_ack, input, 1: backprop/update engine has finished applying its deltas.
REQ-011 The block SHALL provide port ctrl, output, 4: datapath phase code.
REQ-012 The block SHALL provide port step, output, 4: episode step index; 0 means the datapath holds.
REQ-013 The block SHALL provide port st, output, 4: latched state index driven to the weight2 read.
REQ-014 The block SHALL provide port busy, output, 1: high in every state except IDLE.
REQ-015 The block SHALL provide port upd_req, output, 1: request to the update engine.
REQ-016 The block SHALL provide port done, output, 1: one-cycle pulse when a pass completes.
REQ-017 The block SHALL provide port ep_done, output, 1: one-cycle pulse, coincident with done, on the MAX_STEP pass.
REQ-018 The block SHALL provide port err, output, 1: sticky timeout flag; present only when FWD_SEQ_TIMEOUT_EN is defined.

Function
REQ-019 The FSM SHALL have these states and ctrl codes: IDLE=0000, LOAD=0001, HACC=0010, HACT=0011, OACC=0100, OACT=0101, LATCH=0110, UPD=1000, DONE=0111.
REQ-020 ctrl SHALL be a registered, direct function of the current state, with no glitches.
REQ-021 IDLE with start=1 SHALL move to LOAD and capture st_in into st; step SHALL become step+1, or 1 if step was 0 or MAX_STEP.
REQ-022 LOAD SHALL last exactly 1 cycle.
REQ-023 HACC SHALL last HACC_CYC cycles.
REQ-024 HACT SHALL last ACT_CYC cycles.
REQ-025 OACC SHALL last exactly 1 cycle, so the output accumulators add exactly once.
REQ-026 OACT SHALL last ACT_CYC cycles.
REQ-027 LATCH SHALL last exactly 1 cycle.
REQ-028 The cycle-count down-counter SHALL be 4 bits, reload on state entry, and advance on reaching 1.
REQ-029 UPD SHALL assert upd_req and hold it until upd_ack=1 is sampled, then go to DONE.
REQ-030 upd_ack seen in any other state SHALL be ignored.
REQ-031 DONE SHALL last 1 cycle, pulse done, pulse ep_done if step==MAX_STEP, then return to IDLE.
REQ-032 start=0 to 1 latency SHALL be: ctrl=0010 appears 2 cycles after start is sampled.
REQ-033 Total pass length SHALL be 5 + HACC_CYC + 2*ACT_CYC cycles plus upd wait.
REQ-034 start while busy SHALL be ignored, with no queuing.
REQ-035 start and abort in the same IDLE cycle SHALL give abort priority.
REQ-036 abort in any state SHALL, on the next edge, give state=IDLE, step=0, upd_req=0, and no done pulse.
REQ-037 The step after MAX_STEP SHALL wrap to 1 on the next accepted start, never 0.
REQ-038 st SHALL hold its value between passes.

Reset
REQ-039 rst=0 SHALL immediately force state=IDLE, ctrl=0000, step=0, st=0, busy=0, upd_req=0, done=0, ep_done=0, err=0, counter=0.
REQ-040 Reset asserted mid-pass SHALL abandon the pass; after release the block SHALL be in IDLE with no pulse.
REQ-041 Reset removal SHALL be synchronous to clk, so the first active edge is the one after deassertion.

Configuration
REQ-042 Macro FWD_SEQ_TIMEOUT_EN defined: an 8-bit counter SHALL run in UPD; when TO_CYC cycles pass without upd_ack, the FSM SHALL go to DONE, pulse done, and set err, which clears only on reset.
REQ-043 Macro FWD_SEQ_TIMEOUT_EN undefined: UPD SHALL wait indefinitely, and the err port and counter SHALL be absent.

Verification
REQ-044 Reset release, start=1 with st_in=4'h3, upd_ack 1 cycle after upd_req (defaults) -> ctrl sequence 1,2,3,3,4,5,5,6,8,7,0; st=3; step=1; one done pulse.
REQ-045 15 back-to-back passes (MAX_STEP=15) -> step runs 1..15; ep_done only on pass 15; the 16th pass shows step=1.
REQ-046 abort asserted during HACT -> next cycle ctrl=0000, step=0, busy=0, no done; a following start gives step=1.
REQ-047 start pulsed during OACC plus start and abort together in IDLE -> both ignored; state stays in the current pass or IDLE.
REQ-048 rst dropped asynchronously mid-UPD -> outputs reach reset values before the next clk edge.
REQ-049 FWD_SEQ_TIMEOUT_EN with TO_CYC=8 and upd_ack never asserted -> after 8 UPD cycles a done pulse and err=1 that stays high.
